ccff_chain_loader: RTL and testbench
====================================

# ccff_chain_loader

Configuration-chain controller for the tileable k4_N4 fabric. It accepts bitstream words over a valid/ready stream and serializes them onto a `ccff_head`/`ccff_tail` configuration-flop chain, such as the ble4 chain of LUT4 SRAM followed by the output-mux SRAM. It gates chain shifting with an enable so the chain holds whenever the stream stalls. Optionally it verifies the load non-destructively by recirculating the chain once while comparing CRCs.

## Interface
- `CHAIN_LEN`, 18: number of configuration flops in the chain (16 LUT4 bits + 2 mux bits for one ble4).
- `WORD_W`, 8: bitstream word width.
- `CNT_W`, $clog2(CHAIN_LEN+1): width of the bit counter (derived).

Ports:
- `prog_clk`  in  1  programming clock; the only clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle request to begin a load; honoured in IDLE only.
- `verify_en`  in  1  sampled with `start`; 1 = run the VERIFY pass after LOAD.
- `bs_data`  in  WORD_W  bitstream word, bit 0 shifted first.
- `bs_valid`  in  1  `bs_data` valid.
- `bs_ready`  out  1  controller accepts `bs_data` this cycle.
- `ccff_head`  out  1  serial bit into the chain head.
- `ccff_shift_en`  out  1  chain shifts on the `prog_clk` edge ending a cycle in which this is 1.
- `ccff_tail`  in  1  serial bit from the chain tail.
- `busy`  out  1  high in LOAD, VERIFY and DONE.
- `done`  out  1  one-cycle pulse at the end of the operation.
- `error`  out  1  verify CRC mismatch; sticky until the next accepted `start` or `reset`.

## Operation
- States: IDLE, LOAD, VERIFY, DONE.
- IDLE → LOAD on `start`. This transition clears the bit counter, the word buffer, the CRC register and `error`, and latches `verify_en`.
- LOAD, word buffer:
  - One word register with a valid flag and a bit index (0..WORD_W-1).
  - `bs_ready` = buffer empty, OR (valid AND index == WORD_W-1 AND `ccff_shift_en`), AND `bitcnt` + remaining bits < CHAIN_LEN.
  - On `bs_valid && bs_ready` the word loads with index 0.
- LOAD, shifting:
  - `ccff_shift_en` = buffer valid.
  - `ccff_head` = buffer[index], combinational from registered state.
  - On each shift: index++, `bitcnt`++, and the CRC absorbs `ccff_head`.
- LOAD exit: when `bitcnt` reaches CHAIN_LEN, go to VERIFY if verify was latched, else DONE. Unused trailing bits of the final word are discarded.
- Stream stall (buffer empty): `ccff_shift_en` = 0 and the chain holds its contents.
- CRC: CRC-8, polynomial 0x07, init 0x00, MSB-first serial update.
  - LOAD fills `crc_ld`; VERIFY fills `crc_vf`.
- VERIFY:
  - `ccff_shift_en` = 1 for exactly CHAIN_LEN cycles, with `ccff_head` = `ccff_tail` (recirculation, so the configuration is preserved).
  - `crc_vf` absorbs `ccff_tail` each cycle.
  - After CHAIN_LEN cycles: `error` <= (`crc_vf` != `crc_ld`), then go to DONE.
- DONE: `done` = 1 for one cycle, then IDLE.
- `start` outside IDLE is ignored.

## Timing
- Reset values:
  - state IDLE
  - `bs_ready` 0, `ccff_shift_en` 0, `ccff_head` 0, `busy` 0, `done` 0, `error` 0
  - counters 0, CRCs 0x00
- Reset mid-operation: the controller returns to IDLE in the next cycle and shifting stops immediately. Chain contents are undefined and must be reloaded.
- `bs_ready` is first asserted the cycle after `start`. The first shift occurs the cycle after the first handshake.
- Throughput with `bs_valid` held high: one bit per cycle, no bubble between words.
- LOAD lasts CHAIN_LEN cycles plus stall cycles. VERIFY lasts exactly CHAIN_LEN cycles. `done` pulses 1 cycle after the last shift.
- `error` is valid in the cycle `done` is high.
- Handshake rule: `bs_data` is consumed only on `bs_valid && bs_ready`. No word is accepted once CHAIN_LEN bits are committed.

## Structure
- Shared package `ccff_pkg`:
  - state enum `ccff_state_t` (IDLE, LOAD, VERIFY, DONE)
  - `CRC8_POLY` = 8'h07
  - function `crc8_step(crc, bit)`
- Sub-module `ccff_word_serializer`: word buffer, bit index and `bs_ready` logic, instantiated once. The FSM, counter and CRC logic stay in the top.

## Test plan
- CHAIN_LEN=18, WORD_W=8, bs words 0xA5, 0x3C, 0x02 back-to-back, verify off → 18 consecutive `ccff_shift_en` cycles; `ccff_head` sequence 1,0,1,0,0,1,0,1,0,0,1,1,1,1,0,0,0,1; 3 handshakes; `done` one cycle later; `error` 0.
- Same stream with `bs_valid` dropped for 5 cycles after word 1 → `ccff_shift_en` low for exactly those stall cycles; the chain model holds; the final chain contents equal the previous scenario.
- Verify on, with the chain modelled as an 18-bit shift register → VERIFY runs 18 recirculating cycles; the chain contents are unchanged afterwards; `error` 0.
- Verify on, with one chain bit forced inverted during VERIFY → `error` 1 at `done`; `error` stays 1 until the next `start`.
- `reset` asserted mid-LOAD after 9 bits → next cycle IDLE with all outputs at reset values; a subsequent `start` performs a full 18-bit load.
- `start` pulsed during LOAD and during VERIFY → ignored; the cycle count and the `done` timing are unchanged.

Source files
------------

// File: rtl/ccff_pkg.sv
// Shared types and CRC helper for the configuration-chain loader.
package ccff_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StVerify,
    StDone
  } ccff_state_t;

  localparam logic [7:0] CRC8_POLY = 8'h07;

  // One MSB-first serial step of CRC-8.
  function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic din);
    logic fb;
    fb = crc[7] ^ din;
    return {crc[6:0], 1'b0} ^ (fb ? CRC8_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/ccff_word_serializer.sv
// Single-word buffer that turns accepted bitstream words into a serial bit stream.
module ccff_word_serializer
  import ccff_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 18,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              active,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  input  logic [CNT_W-1:0]  bitcnt,
  output logic              bs_ready,
  output logic              buf_valid,
  output logic              head_bit
);

  localparam int unsigned IdxW = (WORD_W > 1) ? $clog2(WORD_W) : 1;

  logic [WORD_W-1:0] data_q;
  logic [IdxW-1:0]   idx_q;
  logic              valid_q;
  logic              last_bit;
  int unsigned       committed;

  // A new word may only be taken if every bit already committed still fits in the chain.
  always_comb begin
    last_bit  = (idx_q == IdxW'(WORD_W - 1));
    committed = 32'(bitcnt) + (valid_q ? (WORD_W - 32'(idx_q)) : 32'd0);
    bs_ready  = active && (!valid_q || last_bit) && (committed < CHAIN_LEN);
  end

  // Leaving the active phase discards any unused trailing bits.
  always_ff @(posedge clk) begin
    if (reset || !active) begin
      valid_q <= 1'b0;
      idx_q   <= '0;
      data_q  <= '0;
    end else if (bs_valid && bs_ready) begin
      valid_q <= 1'b1;
      idx_q   <= '0;
      data_q  <= bs_data;
    end else if (valid_q) begin
      if (last_bit) begin
        valid_q <= 1'b0;
      end
      idx_q <= last_bit ? '0 : idx_q + 1'b1;
    end
  end

  assign buf_valid = valid_q;
  assign head_bit  = data_q[idx_q];

endmodule

// File: rtl/ccff_chain_loader.sv
// Loads a configuration-flop chain from a bitstream stream, with optional
// non-destructive CRC verification by recirculating the chain once.
module ccff_chain_loader
  import ccff_pkg::*;
#(
  parameter int unsigned CHAIN_LEN = 18,
  parameter int unsigned WORD_W    = 8,
  parameter int unsigned CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              reset,
  input  logic              start,
  input  logic              verify_en,
  input  logic [WORD_W-1:0] bs_data,
  input  logic              bs_valid,
  output logic              bs_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error
);

  ccff_state_t      state_q, state_d;
  logic [CNT_W-1:0] bitcnt_q;
  logic [7:0]       crc_ld_q, crc_vf_q, crc_vf_next;
  logic             verify_q, error_q;
  logic             ser_active, buf_valid, buf_head;
  logic             load_shift, last_cnt;

  // Reset gates shifting in the same cycle so the chain stops immediately.
  assign ser_active  = (state_q == StLoad) && !reset;
  assign load_shift  = ser_active && buf_valid;
  assign last_cnt    = (bitcnt_q == CNT_W'(CHAIN_LEN - 1));
  assign crc_vf_next = crc8_step(crc_vf_q, ccff_tail);

  ccff_word_serializer #(
    .CHAIN_LEN(CHAIN_LEN),
    .WORD_W   (WORD_W),
    .CNT_W    (CNT_W)
  ) u_serializer (
    .clk      (prog_clk),
    .reset    (reset),
    .active   (ser_active),
    .bs_data  (bs_data),
    .bs_valid (bs_valid),
    .bitcnt   (bitcnt_q),
    .bs_ready (bs_ready),
    .buf_valid(buf_valid),
    .head_bit (buf_head)
  );

  always_ff @(posedge prog_clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (start) state_d = StLoad;
      end
      StLoad: begin
        if (load_shift && last_cnt) state_d = verify_q ? StVerify : StDone;
      end
      StVerify: begin
        if (last_cnt) state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Bit counter is reused as the recirculation counter during verify.
  always_ff @(posedge prog_clk) begin
    if (reset) begin
      bitcnt_q <= '0;
      crc_ld_q <= 8'h00;
      crc_vf_q <= 8'h00;
      verify_q <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            bitcnt_q <= '0;
            crc_ld_q <= 8'h00;
            crc_vf_q <= 8'h00;
            error_q  <= 1'b0;
            verify_q <= verify_en;
          end
        end
        StLoad: begin
          if (load_shift) begin
            crc_ld_q <= crc8_step(crc_ld_q, buf_head);
            bitcnt_q <= last_cnt ? '0 : bitcnt_q + 1'b1;
          end
        end
        StVerify: begin
          crc_vf_q <= crc_vf_next;
          bitcnt_q <= last_cnt ? '0 : bitcnt_q + 1'b1;
          if (last_cnt) begin
            error_q <= (crc_vf_next != crc_ld_q);
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    busy          = 1'b0;
    done          = 1'b0;
    ccff_shift_en = 1'b0;
    ccff_head     = 1'b0;
    unique case (state_q)
      StIdle: ;
      StLoad: begin
        busy          = 1'b1;
        ccff_shift_en = load_shift;
        ccff_head     = buf_head;
      end
      StVerify: begin
        busy          = 1'b1;
        ccff_shift_en = !reset;
        ccff_head     = ccff_tail;
      end
      StDone: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  assign error = error_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: directed scenarios plus randomized loads against a chain model.
module tb_ccff_chain_loader;

  localparam int unsigned CL = 18;
  localparam int unsigned W  = 8;
  localparam int unsigned NW = (CL + W - 1) / W;

  logic          prog_clk = 1'b0;
  logic          reset, start, verify_en, bs_valid, bs_ready;
  logic          ccff_head, ccff_shift_en, ccff_tail, busy, done, error;
  logic [W-1:0]  bs_data;
  logic [CL-1:0] chain;
  logic [CL-1:0] golden_chain;
  logic          inject;
  logic [W-1:0]  words [NW+1];

  int n_cmp = 0;
  int n_bad = 0;

  logic s_ready, s_shift, s_head, s_tail, s_busy, s_done, s_error, s_valid;

  // Chain model: bit enters at index 0 and leaves from the top; inject flips the tail.
  assign ccff_tail = chain[CL-1] ^ inject;

  always #5 prog_clk = ~prog_clk;

  ccff_chain_loader #(
    .CHAIN_LEN(CL),
    .WORD_W   (W)
  ) dut (
    .prog_clk     (prog_clk),
    .reset        (reset),
    .start        (start),
    .verify_en    (verify_en),
    .bs_data      (bs_data),
    .bs_valid     (bs_valid),
    .bs_ready     (bs_ready),
    .ccff_head    (ccff_head),
    .ccff_shift_en(ccff_shift_en),
    .ccff_tail    (ccff_tail),
    .busy         (busy),
    .done         (done),
    .error        (error)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    #1;
    s_ready = bs_ready;
    s_shift = ccff_shift_en;
    s_head  = ccff_head;
    s_tail  = ccff_tail;
    s_busy  = busy;
    s_done  = done;
    s_error = error;
    s_valid = bs_valid;
  endtask

  // Sample mid-cycle, then advance one edge and apply the shift the DUT requested.
  task automatic tick();
    sample();
    @(posedge prog_clk);
    #1;
    if (s_shift) chain = {chain[CL-2:0], s_head};
  endtask

  task automatic do_load(input bit v, input int hold_after, input int hold_len,
                         input bit rnd_valid, input int fault_at,
                         input int start_a, input int start_b);
    logic [CL-1:0] exp_chain;
    int wi, nsh, stalls, busy_low, hold_left, done_cyc;
    wi = 0; nsh = 0; stalls = 0; busy_low = 0; hold_left = 0; done_cyc = -1;
    for (int k = 0; k < int'(CL); k++) exp_chain[CL-1-k] = words[k/W][k%W];

    start = 1'b1; verify_en = v; bs_valid = 1'b0; bs_data = W'($urandom); inject = 1'b0;
    tick();
    check("idle_ready", 32'(s_ready), 32'd0);
    check("idle_busy", 32'(s_busy), 32'd0);
    start = 1'b0;
    for (int cyc = 1; cyc < 200 && done_cyc < 0; cyc++) begin
      start     = (cyc == start_a) || (cyc == start_b);
      verify_en = 1'($urandom);
      inject    = (fault_at >= 0) && (nsh == int'(CL) + fault_at);
      // One extra word is offered to prove nothing is taken once the chain is full.
      bs_valid  = (wi <= int'(NW)) && (hold_left == 0) &&
                  (!rnd_valid || $urandom_range(0, 2) != 0);
      bs_data   = bs_valid ? words[wi] : W'($urandom);
      tick();
      if (cyc == 1) begin
        check("ready_after_start", 32'(s_ready), 32'd1);
        check("error_cleared", 32'(s_error), 32'd0);
      end
      if (!s_busy) busy_low++;
      if (wi < int'(NW) && s_ready && !s_valid) begin
        stalls++;
        if (hold_left > 0) hold_left--;
      end
      if (s_valid && s_ready) begin
        wi++;
        if (wi == hold_after) hold_left = hold_len;
      end
      if (s_shift) begin
        if (nsh < int'(CL)) check($sformatf("head_bit%0d", nsh), 32'(s_head),
                                  32'(words[nsh/W][nsh%W]));
        else check($sformatf("recirc%0d", nsh - int'(CL)), 32'(s_head), 32'(s_tail));
        nsh++;
      end
      if (s_done) begin
        done_cyc = cyc;
        check("done_error", 32'(s_error), 32'(fault_at >= 0));
      end
    end
    inject   = 1'b0;
    bs_valid = 1'b0;
    start    = 1'b0;
    check("done_cycle", 32'(done_cyc), 32'(20 + stalls + (v ? 18 : 0)));
    check("handshakes", 32'(wi), 32'(NW));
    check("shift_count", 32'(nsh), 32'(v ? 2 * CL : CL));
    check("busy_gap", 32'(busy_low), 32'd0);
    if (fault_at < 0) check("chain_contents", 32'(chain), 32'(exp_chain));
    tick();
    check("done_single", 32'(s_done), 32'd0);
    check("idle_after", 32'(s_busy), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    bit v;
    int f;
    reset = 1'b1; start = 1'b0; verify_en = 1'b0; bs_valid = 1'b0; bs_data = '0;
    inject = 1'b0; chain = '0;
    @(posedge prog_clk);
    #1;
    tick();
    tick();
    reset = 1'b0;
    tick();
    check("rst_ready", 32'(s_ready), 32'd0);
    check("rst_shift", 32'(s_shift), 32'd0);
    check("rst_head", 32'(s_head), 32'd0);
    check("rst_busy", 32'(s_busy), 32'd0);
    check("rst_done", 32'(s_done), 32'd0);
    check("rst_error", 32'(s_error), 32'd0);

    // Plain load of the reference stream.
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'h02; words[3] = 8'hFF;
    do_load(1'b0, -1, 0, 1'b0, -1, -1, -1);
    golden_chain = chain;

    // Same stream with a five-cycle gap before the second word.
    chain = '0;
    do_load(1'b0, 1, 5, 1'b0, -1, -1, -1);
    check("stall_chain", 32'(chain), 32'(golden_chain));

    // Verified load leaves the chain unchanged.
    do_load(1'b1, -1, 0, 1'b0, -1, -1, -1);
    check("verify_chain", 32'(chain), 32'(golden_chain));

    // Corrupted recirculation raises a sticky error.
    do_load(1'b1, -1, 0, 1'b0, 7, -1, -1);
    tick();
    tick();
    check("error_sticky", 32'(s_error), 32'd1);

    // Reset in the middle of a load.
    start = 1'b1; verify_en = 1'b0;
    tick();
    start = 1'b0;
    begin
      int wi, nsh;
      wi = 0; nsh = 0;
      for (int c = 0; c < 40 && nsh < 9; c++) begin
        bs_valid = (wi < int'(NW));
        bs_data  = words[wi];
        tick();
        if (s_valid && s_ready) wi++;
        if (s_shift) nsh++;
      end
      check("pre_reset_bits", 32'(nsh), 32'd9);
    end
    reset = 1'b1;
    tick();
    check("reset_cycle_shift", 32'(s_shift), 32'd0);
    reset = 1'b0; bs_valid = 1'b0;
    tick();
    check("post_rst_ready", 32'(s_ready), 32'd0);
    check("post_rst_shift", 32'(s_shift), 32'd0);
    check("post_rst_head", 32'(s_head), 32'd0);
    check("post_rst_busy", 32'(s_busy), 32'd0);
    check("post_rst_done", 32'(s_done), 32'd0);
    check("post_rst_error", 32'(s_error), 32'd0);
    do_load(1'b0, -1, 0, 1'b0, -1, -1, -1);

    // Start pulses during LOAD and VERIFY are ignored.
    do_load(1'b1, -1, 0, 1'b0, -1, 5, 25);

    for (int it = 0; it < 8; it++) begin
      for (int w = 0; w <= int'(NW); w++) words[w] = W'($urandom);
      v = 1'($urandom);
      f = (v && $urandom_range(0, 2) == 0) ? int'($urandom_range(0, CL - 1)) : -1;
      do_load(v, -1, 0, 1'b1, f, -1, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
